// File: rtl/bcd_step_sched.sv
// bcd_step_sched: two-digit BCD up/down counter shared by two requesters.
//
// Each accepted request performs one step of the counter. A round-robin
// arbiter resolves simultaneous requests. A step takes one ONES cycle, plus
// one TENS cycle when the ones digit carries or borrows.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   req_a, dir_a   requester A level request / direction (1 = up, 0 = down)
//   req_b, dir_b   requester B level request / direction
//   grant_a/_b     one-cycle registered grant pulse (first ONES cycle)
//   ones, tens     registered BCD digits (0-9)
//   busy           high whenever the FSM is not in IDLE
//   lim            one-cycle pulse on wrap (or saturation) events
//
// Parameters: RESET_ONES, RESET_TENS (0-9) digit values loaded on reset.
// Compile-time option: define BCD_SCHED_SAT_EN to saturate at 00/99
// instead of wrapping modulo 100.
module bcd_step_sched #(
    parameter int unsigned RESET_ONES = 0,
    parameter int unsigned RESET_TENS = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       dir_a,
    input  logic       req_b,
    input  logic       dir_b,
    output logic       grant_a,
    output logic       grant_b,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       busy,
    output logic       lim
);

    localparam logic [3:0] ONES_INIT = 4'(RESET_ONES);
    localparam logic [3:0] TENS_INIT = 4'(RESET_TENS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        TENS = 2'd2
    } state_t;

    state_t state, state_nx;

    logic step_up;    // latched direction of the step in flight
    logic prio_b;     // 1: B wins a tie (A was granted last)
    logic win_a, win_b;
    logic ones_edge;  // ones digit will carry/borrow
    logic tens_edge;  // tens digit will wrap
    logic sat_hit;

    function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
        if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
        else    return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

    assign ones_edge = step_up ? (ones == 4'd9) : (ones == 4'd0);
    assign tens_edge = step_up ? (tens == 4'd9) : (tens == 4'd0);

`ifdef BCD_SCHED_SAT_EN
    // Counter pinned at its end: the step is granted but changes nothing.
    assign sat_hit = ones_edge && tens_edge;
`else
    assign sat_hit = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        win_a    = 1'b0;
        win_b    = 1'b0;
        case (state)
            IDLE: begin
                // A lone request always wins; the pointer only breaks ties.
                if (req_a && (!req_b || !prio_b)) win_a = 1'b1;
                else if (req_b)                   win_b = 1'b1;
                if (req_a || req_b) state_nx = ONES;
            end
            ONES: begin
                if (ones_edge && !sat_hit) state_nx = TENS;
                else                       state_nx = IDLE;
            end
            TENS:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ones    <= ONES_INIT;
            tens    <= TENS_INIT;
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            lim     <= 1'b0;
            prio_b  <= 1'b0;
            step_up <= 1'b0;
        end else begin
            state   <= state_nx;
            grant_a <= win_a;
            grant_b <= win_b;
            lim     <= 1'b0;
            if (win_a) begin
                step_up <= dir_a;
                prio_b  <= 1'b1;
            end
            if (win_b) begin
                step_up <= dir_b;
                prio_b  <= 1'b0;
            end
            case (state)
                ONES: begin
                    if (sat_hit) lim  <= 1'b1;
                    else         ones <= bcd_step(ones, step_up);
                end
                TENS: begin
                    tens <= bcd_step(tens, step_up);
                    if (tens_edge) lim <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
